// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: stall/flush sequencing for the 5-stage pipeline
// and start/busy/done sequencing for the multi-cycle HI/LO mul/div unit.
//
// state | meaning
// IDLE  | mul/div unit free, a mult/div in ID may start
// BUSY  | mul/div unit computing, cnt counts down to terminal count 0
// DONE  | result written to HI/LO this cycle (MD_Done high), unit still occupied
module pipeline_hazard_ctrl #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_UsesRs,
  input  logic        ID_UsesRt,
  input  logic        ID_ReadsHiLo,
  input  logic        ID_MulDiv,
  input  logic        ID_IsDiv,
  input  logic        ID_Redirect,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_RegDstData,
  input  logic        Hold,
  output logic        PC_Ld,
  output logic        IFID_Ld,
  output logic        IFID_Clr,
  output logic        IDEX_Ld,
  output logic        IDEX_Clr,
  output logic        EXMEM_Ld,
  output logic        EXMEM_Clr,
  output logic        MEMWB_Ld,
  output logic        MEMWB_Clr,
  output logic        MD_Start,
  output logic        MD_Busy,
  output logic        MD_Done,
  output logic [31:0] StallCount
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [5:0] MulLoad = 6'(MULT_CYCLES - 1);
  localparam logic [5:0] DivLoad = 6'(DIV_CYCLES - 1);

  state_t     state;
  logic [5:0] cnt;
  logic       loadUse;
  logic       hiLoHaz;
  logic       stall;

  // Hazard detection; DONE still counts as occupied so mfhi waits one more cycle
  always_comb begin
    loadUse = EX_MemRead && (EX_RegDstData != 5'd0) &&
              ((ID_UsesRs && (ID_Rs == EX_RegDstData)) ||
               (ID_UsesRt && (ID_Rt == EX_RegDstData)));
    hiLoHaz = (ID_ReadsHiLo || ID_MulDiv) && (state != IDLE);
    stall   = (loadUse || hiLoHaz) && !Hold;
  end

  // Pipeline register controls, priority reset > hold > stall > redirect > normal
  always_comb begin
    PC_Ld     = 1'b1;
    IFID_Ld   = 1'b1;
    IFID_Clr  = 1'b0;
    IDEX_Ld   = 1'b1;
    IDEX_Clr  = 1'b0;
    EXMEM_Ld  = 1'b1;
    EXMEM_Clr = 1'b0;
    MEMWB_Ld  = 1'b1;
    MEMWB_Clr = 1'b0;
    MD_Start  = ID_MulDiv && (state == IDLE) && !loadUse && !Hold && !Clr;
    if (Clr) begin
      PC_Ld     = 1'b0;
      IFID_Ld   = 1'b0;
      IFID_Clr  = 1'b1;
      IDEX_Ld   = 1'b0;
      IDEX_Clr  = 1'b1;
      EXMEM_Ld  = 1'b0;
      EXMEM_Clr = 1'b1;
      MEMWB_Ld  = 1'b0;
      MEMWB_Clr = 1'b1;
    end else if (Hold) begin
      PC_Ld    = 1'b0;
      IFID_Ld  = 1'b0;
      IDEX_Ld  = 1'b0;
      EXMEM_Ld = 1'b0;
      MEMWB_Ld = 1'b0;
    end else if (stall) begin
      // Freeze PC and IF/ID, inject a bubble into ID/EX, let older stages drain
      PC_Ld    = 1'b0;
      IFID_Ld  = 1'b0;
      IDEX_Clr = 1'b1;
      MD_Start = 1'b0;
    end else if (ID_Redirect) begin
      IFID_Clr = 1'b1;
    end
  end

  assign MD_Busy = (state != IDLE);

  // Mul/div sequencer: down-counter to terminal count, then one-cycle HI/LO write
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state   <= IDLE;
      cnt     <= 6'd0;
      MD_Done <= 1'b0;
    end else begin
      MD_Done <= 1'b0;
      case (state)
        IDLE: begin
          if (MD_Start) begin
            cnt   <= ID_IsDiv ? DivLoad : MulLoad;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == 6'd0) begin
            state   <= DONE;
            MD_Done <= 1'b1;
          end else begin
            cnt <= cnt - 6'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Saturating stall-cycle counter
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      StallCount <= 32'd0;
    end else if (stall && (StallCount != 32'hFFFF_FFFF)) begin
      StallCount <= StallCount + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with hand-computed expectations.
module tb_pipeline_hazard_ctrl;

  logic        Clk;
  logic        Clr;
  logic [4:0]  ID_Rs, ID_Rt;
  logic        ID_UsesRs, ID_UsesRt, ID_ReadsHiLo, ID_MulDiv, ID_IsDiv, ID_Redirect;
  logic        EX_MemRead;
  logic [4:0]  EX_RegDstData;
  logic        Hold;
  logic        PC_Ld, IFID_Ld, IFID_Clr, IDEX_Ld, IDEX_Clr;
  logic        EXMEM_Ld, EXMEM_Clr, MEMWB_Ld, MEMWB_Clr;
  logic        MD_Start, MD_Busy, MD_Done;
  logic [31:0] StallCount;

  int nCmp = 0;
  int nErr = 0;
  int sawDone;

  pipeline_hazard_ctrl #(.MULT_CYCLES(4), .DIV_CYCLES(32)) dut (
    .Clk(Clk), .Clr(Clr),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .ID_ReadsHiLo(ID_ReadsHiLo), .ID_MulDiv(ID_MulDiv), .ID_IsDiv(ID_IsDiv),
    .ID_Redirect(ID_Redirect), .EX_MemRead(EX_MemRead), .EX_RegDstData(EX_RegDstData),
    .Hold(Hold),
    .PC_Ld(PC_Ld), .IFID_Ld(IFID_Ld), .IFID_Clr(IFID_Clr), .IDEX_Ld(IDEX_Ld),
    .IDEX_Clr(IDEX_Clr), .EXMEM_Ld(EXMEM_Ld), .EXMEM_Clr(EXMEM_Clr),
    .MEMWB_Ld(MEMWB_Ld), .MEMWB_Clr(MEMWB_Clr),
    .MD_Start(MD_Start), .MD_Busy(MD_Busy), .MD_Done(MD_Done), .StallCount(StallCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to 1 time unit after the next rising edge: start of a new cycle
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clrIn();
    ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRs = 1'b0; ID_UsesRt = 1'b0;
    ID_ReadsHiLo = 1'b0; ID_MulDiv = 1'b0; ID_IsDiv = 1'b0; ID_Redirect = 1'b0;
    EX_MemRead = 1'b0; EX_RegDstData = 5'd0; Hold = 1'b0;
  endtask

  task automatic setLU();
    EX_MemRead = 1'b1; EX_RegDstData = 5'd8; ID_Rs = 5'd8; ID_UsesRs = 1'b1;
  endtask

  initial begin
    clrIn();
    Clr = 1'b1;
    ID_MulDiv = 1'b1;
    #3;
    // Reset: forced outputs, MD_Start suppressed even with a mult in ID
    chk("rst_PC_Ld", 32'(PC_Ld), 32'd0);
    chk("rst_IFID_Clr", 32'(IFID_Clr), 32'd1);
    chk("rst_MEMWB_Clr", 32'(MEMWB_Clr), 32'd1);
    chk("rst_MD_Start", 32'(MD_Start), 32'd0);
    chk("rst_MD_Busy", 32'(MD_Busy), 32'd0);
    chk("rst_StallCount", StallCount, 32'd0);
    ID_MulDiv = 1'b0;
    #9 Clr = 1'b0;   // released between edges
    tick();

    // Normal flow
    chk("norm_PC_Ld", 32'(PC_Ld), 32'd1);
    chk("norm_IDEX_Clr", 32'(IDEX_Clr), 32'd0);
    chk("norm_IFID_Clr", 32'(IFID_Clr), 32'd0);

    // 1. Load-use on rs
    setLU();
    #1;
    chk("lu_PC_Ld", 32'(PC_Ld), 32'd0);
    chk("lu_IFID_Ld", 32'(IFID_Ld), 32'd0);
    chk("lu_IDEX_Clr", 32'(IDEX_Clr), 32'd1);
    chk("lu_EXMEM_Ld", 32'(EXMEM_Ld), 32'd1);
    chk("lu_MEMWB_Ld", 32'(MEMWB_Ld), 32'd1);
    chk("lu_IFID_Clr", 32'(IFID_Clr), 32'd0);
    chk("lu_sc_before", StallCount, 32'd0);
    tick();
    chk("lu_sc_after", StallCount, 32'd1);
    EX_RegDstData = 5'd0; ID_Rs = 5'd0;
    #1;
    chk("lu_r0_PC_Ld", 32'(PC_Ld), 32'd1);
    chk("lu_r0_IDEX_Clr", 32'(IDEX_Clr), 32'd0);
    tick();
    chk("lu_r0_sc", StallCount, 32'd1);
    // Load-use on rt, then gated off by UsesRt
    clrIn();
    EX_MemRead = 1'b1; EX_RegDstData = 5'd5; ID_Rt = 5'd5; ID_UsesRt = 1'b1; ID_Rs = 5'd5;
    #1;
    chk("lu_rt_PC_Ld", 32'(PC_Ld), 32'd0);
    tick();
    chk("lu_rt_sc", StallCount, 32'd2);
    ID_UsesRt = 1'b0;
    #1;
    chk("lu_rt_unused_PC_Ld", 32'(PC_Ld), 32'd1);
    // Load does not stall if EX is not a load
    ID_UsesRt = 1'b1; EX_MemRead = 1'b0;
    #1;
    chk("lu_noload_PC_Ld", 32'(PC_Ld), 32'd1);
    clrIn();

    // 2. Redirect, then redirect overridden by load-use
    ID_Redirect = 1'b1;
    #1;
    chk("br_IFID_Clr", 32'(IFID_Clr), 32'd1);
    chk("br_PC_Ld", 32'(PC_Ld), 32'd1);
    chk("br_IFID_Ld", 32'(IFID_Ld), 32'd1);
    chk("br_IDEX_Clr", 32'(IDEX_Clr), 32'd0);
    setLU();
    #1;
    chk("br_lu_IFID_Clr", 32'(IFID_Clr), 32'd0);
    chk("br_lu_IDEX_Clr", 32'(IDEX_Clr), 32'd1);
    chk("br_lu_PC_Ld", 32'(PC_Ld), 32'd0);
    clrIn();
    tick();

    // 3. Multiply, mfhi waiting behind it
    ID_MulDiv = 1'b1;
    #1;
    chk("mul_start", 32'(MD_Start), 32'd1);
    chk("mul_busy_c0", 32'(MD_Busy), 32'd0);
    tick();
    ID_MulDiv = 1'b0; ID_ReadsHiLo = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      #1;
      chk($sformatf("mul_busy_c%0d", c), 32'(MD_Busy), 32'd1);
      chk($sformatf("mul_done_c%0d", c), 32'(MD_Done), 32'(c == 5));
      chk($sformatf("mfhi_stall_c%0d", c), 32'(PC_Ld), 32'd0);
      tick();
    end
    #1;
    chk("mfhi_issue_PC_Ld", 32'(PC_Ld), 32'd1);
    chk("mul_busy_c6", 32'(MD_Busy), 32'd0);
    chk("mul_done_c6", 32'(MD_Done), 32'd0);
    chk("mul_sc", StallCount, 32'd7);
    clrIn();
    tick();

    // 4. Divide, then mult waiting in ID
    ID_MulDiv = 1'b1; ID_IsDiv = 1'b1;
    #1;
    chk("div_start", 32'(MD_Start), 32'd1);
    tick();
    ID_IsDiv = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      #1;
      chk($sformatf("div_stall_c%0d", c), 32'(PC_Ld), 32'd0);
      chk($sformatf("div_nostart_c%0d", c), 32'(MD_Start), 32'd0);
      chk($sformatf("div_done_c%0d", c), 32'(MD_Done), 32'(c == 33));
      tick();
    end
    #1;
    chk("mul2_start_c34", 32'(MD_Start), 32'd1);
    chk("mul2_PC_Ld_c34", 32'(PC_Ld), 32'd1);
    chk("mul2_done_c34", 32'(MD_Done), 32'd0);
    tick();
    ID_MulDiv = 1'b0;
    for (int c = 35; c <= 39; c++) begin
      #1;
      chk($sformatf("mul2_busy_c%0d", c), 32'(MD_Busy), 32'd1);
      chk($sformatf("mul2_done_c%0d", c), 32'(MD_Done), 32'(c == 39));
      tick();
    end
    #1;
    chk("mul2_busy_c40", 32'(MD_Busy), 32'd0);
    chk("div_sc", StallCount, 32'd40);
    clrIn();

    // 5. Hold during a busy mult with concurrent load-use and mfhi
    ID_MulDiv = 1'b1;
    #1;
    chk("hold_mul_start", 32'(MD_Start), 32'd1);
    tick();
    ID_MulDiv = 1'b0; ID_ReadsHiLo = 1'b1; Hold = 1'b1;
    setLU();
    for (int c = 1; c <= 5; c++) begin
      #1;
      chk($sformatf("hold_PC_Ld_c%0d", c), 32'(PC_Ld), 32'd0);
      chk($sformatf("hold_EXMEM_Ld_c%0d", c), 32'(EXMEM_Ld), 32'd0);
      chk($sformatf("hold_IDEX_Clr_c%0d", c), 32'(IDEX_Clr), 32'd0);
      chk($sformatf("hold_IFID_Clr_c%0d", c), 32'(IFID_Clr), 32'd0);
      chk($sformatf("hold_done_c%0d", c), 32'(MD_Done), 32'(c == 5));
      tick();
    end
    #1;
    chk("hold_busy_c6", 32'(MD_Busy), 32'd0);
    chk("hold_sc", StallCount, 32'd40);
    clrIn();
    tick();

    // 6. Asynchronous reset mid-divide
    ID_MulDiv = 1'b1; ID_IsDiv = 1'b1;
    tick();
    clrIn();
    repeat (10) tick();
    chk("rst_div_busy_before", 32'(MD_Busy), 32'd1);
    #2 Clr = 1'b1;
    #1;
    chk("arst_MD_Busy", 32'(MD_Busy), 32'd0);
    chk("arst_PC_Ld", 32'(PC_Ld), 32'd0);
    chk("arst_EXMEM_Ld", 32'(EXMEM_Ld), 32'd0);
    chk("arst_IDEX_Clr", 32'(IDEX_Clr), 32'd1);
    chk("arst_EXMEM_Clr", 32'(EXMEM_Clr), 32'd1);
    chk("arst_StallCount", StallCount, 32'd0);
    tick();
    #2 Clr = 1'b0;
    sawDone = 0;
    repeat (40) begin
      tick();
      if (MD_Done) sawDone++;
    end
    chk("arst_no_done", 32'(sawDone), 32'd0);
    chk("arst_busy_after", 32'(MD_Busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
